// File: rtl/issue_scoreboard_pkg.sv
// Shared types and latency rules for the issue scoreboard.
// Execution classes, their result latencies and divider membership.
package issue_scoreboard_pkg;

  typedef enum logic [3:0] {
    ENop    = 4'd0,
    EAdd    = 4'd1,
    ESub    = 4'd2,
    ERshift = 4'd3,
    ELshift = 4'd4,
    EFadd   = 4'd5,
    EFsub   = 4'd6,
    EFmul   = 4'd7,
    EFdiv   = 4'd8,
    EFsqrt  = 4'd9,
    EFtoi   = 4'd10,
    EItof   = 4'd11
  } exec_type;

  localparam int unsigned LAT_NOP  = 0;
  localparam int unsigned LAT_ALU  = 1;
  localparam int unsigned LAT_FMUL = 2;
  localparam int unsigned LAT_FADD = 3;

  function automatic int unsigned exec_latency(
    input exec_type    e,
    input int unsigned div_lat
  );
    unique case (e)
      EAdd, ESub, ERshift, ELshift: return LAT_ALU;
      EFmul, EFtoi, EItof:          return LAT_FMUL;
      EFadd, EFsub:                 return LAT_FADD;
      EFdiv, EFsqrt:                return div_lat;
      default:                      return LAT_NOP;
    endcase
  endfunction

  function automatic logic is_div_op(input exec_type e);
    return (e == EFdiv) || (e == EFsqrt);
  endfunction

endpackage

// File: rtl/sb_counter_bank.sv
// Per-register countdown counters tracking pending writes.
// Register 0 has no counter and always reads as idle.
module sb_counter_bank #(
  parameter int NUM_REGS = 32,
  parameter int LAT_W    = 4,
  parameter int RW       = $clog2(NUM_REGS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           load,
  input  logic [RW-1:0]                  load_idx,
  input  logic [LAT_W-1:0]               load_val,
  output logic [NUM_REGS-1:0][LAT_W-1:0] cnt,
  output logic [NUM_REGS-1:0]            busy
);

  logic [LAT_W-1:0] cnt_q [NUM_REGS-1:1];

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q[r] <= '0;
      end else if (load && load_idx == RW'(r)) begin
        cnt_q[r] <= load_val;
      end else if (cnt_q[r] != '0) begin
        cnt_q[r] <= cnt_q[r] - 1'b1;
      end
    end
  end

  always_comb begin
    cnt  = '0;
    busy = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      cnt[i]  = cnt_q[i];
      busy[i] = |cnt_q[i];
    end
  end

endmodule

// File: rtl/issue_scoreboard.sv
// Issue stage: RAW/WAW/divider hazard checks in front of a
// registered valid/ready slot feeding execute.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int LAT_W    = 4,
  parameter int DIV_LAT  = 12,
  parameter int RW       = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  exec_type      in_exec,
  input  logic [RW-1:0] in_rd,
  input  logic [RW-1:0] in_rs1,
  input  logic [RW-1:0] in_rs2,
  input  logic          in_use1,
  input  logic          in_use2,
  input  logic          in_we,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output exec_type      out_exec,
  output logic [RW-1:0] out_rd,
  output logic [RW-1:0] out_rs1,
  output logic [RW-1:0] out_rs2,
  output logic          out_we
);

  logic [NUM_REGS-1:0][LAT_W-1:0] cnt;
  logic [NUM_REGS-1:0]            busy;
  logic [LAT_W-1:0]               div_cnt;
  logic [LAT_W:0]                 lat;
  logic [LAT_W-1:0]               lat_m1;
  logic we_eff, div_op, raw, waw, div_hz, fire;

  assign lat    = (LAT_W+1)'(exec_latency(in_exec, DIV_LAT));
  assign lat_m1 = LAT_W'(lat - 1'b1);
  assign we_eff = in_we && (in_exec != ENop);
  assign div_op = is_div_op(in_exec);

  // busy[0] is tied low, so r0 never raises a hazard
  assign raw = (in_use1 && busy[in_rs1])
            || (in_use2 && busy[in_rs2]);
  assign waw = we_eff && busy[in_rd]
            && (cnt[in_rd] >= lat_m1);
  assign div_hz = div_op && (div_cnt != '0);

  assign in_ready = !(raw || waw || div_hz)
                 && (!out_valid || out_ready)
                 && !flush;
  assign fire = in_valid && in_ready;

  sb_counter_bank #(
    .NUM_REGS (NUM_REGS),
    .LAT_W    (LAT_W),
    .RW       (RW)
  ) u_bank (
    .clk      (clk),
    .rst      (rst),
    .load     (fire && we_eff && in_rd != '0),
    .load_idx (in_rd),
    .load_val (lat_m1),
    .cnt      (cnt),
    .busy     (busy)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (fire && div_op) begin
      div_cnt <= LAT_W'(DIV_LAT - 1);
    end else if (div_cnt != '0) begin
      div_cnt <= div_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_exec  <= ENop;
      out_rd    <= '0;
      out_rs1   <= '0;
      out_rs2   <= '0;
      out_we    <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (fire) begin
      out_valid <= 1'b1;
      out_exec  <= in_exec;
      out_rd    <= in_rd;
      out_rs1   <= in_rs1;
      out_rs2   <= in_rs2;
      out_we    <= we_eff;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: directed hazard scenarios plus a
// random run against a cycle-time model of register availability.
module tb_issue_scoreboard;
  import issue_scoreboard_pkg::*;

  localparam int NUM_REGS = 32;
  localparam int LAT_W    = 4;
  localparam int DIV_LAT  = 12;
  localparam int RW       = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  exec_type      in_exec = ENop;
  logic [RW-1:0] in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic          in_use1 = 1'b0, in_use2 = 1'b0, in_we = 1'b0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  exec_type      out_exec;
  logic [RW-1:0] out_rd, out_rs1, out_rs2;
  logic          out_we;

  int errors = 0;
  int checks = 0;

  issue_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .LAT_W    (LAT_W),
    .DIV_LAT  (DIV_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_exec   (in_exec),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_use1   (in_use1),
    .in_use2   (in_use2),
    .in_we     (in_we),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_exec  (out_exec),
    .out_rd    (out_rd),
    .out_rs1   (out_rs1),
    .out_rs2   (out_rs2),
    .out_we    (out_we)
  );

  always #5 clk = ~clk;

  // Model: absolute cycle at which each register's result is available
  longint   now;
  longint   avail [NUM_REGS];
  longint   div_free;
  bit       m_ov;
  exec_type m_exec;
  logic [RW-1:0] m_rd, m_rs1;
  bit       m_we;

  function automatic int lat(exec_type e);
    case (e)
      EAdd, ESub, ERshift, ELshift: return 1;
      EFmul, EFtoi, EItof:          return 2;
      EFadd, EFsub:                 return 3;
      EFdiv, EFsqrt:                return DIV_LAT;
      default:                      return 0;
    endcase
  endfunction

  function automatic bit m_ready();
    bit hz;
    int l;
    bit we;
    l  = lat(in_exec);
    we = in_we && in_exec != ENop;
    hz = (in_use1 && in_rs1 != 0 && avail[in_rs1] > now)
      || (in_use2 && in_rs2 != 0 && avail[in_rs2] > now);
    if (we && in_rd != 0 && avail[in_rd] > now
        && avail[in_rd] >= now + l - 1)
      hz = 1;
    if ((in_exec == EFdiv || in_exec == EFsqrt) && div_free > now)
      hz = 1;
    return !hz && (!m_ov || out_ready) && !flush;
  endfunction

  task automatic m_clear();
    now = 0;
    div_free = 0;
    foreach (avail[i]) avail[i] = 0;
    m_ov = 0;
    m_exec = ENop;
    m_rd = '0;
    m_rs1 = '0;
    m_we = 0;
  endtask

  task automatic tick(output bit f);
    bit r;
    int l;
    r = m_ready();
    f = in_valid && r;
    l = lat(in_exec);
    @(posedge clk);
    if (flush) begin
      m_ov = 0;
    end else if (f) begin
      m_ov   = 1;
      m_exec = in_exec;
      m_rd   = in_rd;
      m_rs1  = in_rs1;
      m_we   = in_we && in_exec != ENop;
      if (m_we && in_rd != 0) avail[in_rd] = now + l;
      if (in_exec == EFdiv || in_exec == EFsqrt)
        div_free = now + DIV_LAT;
    end else if (out_ready) begin
      m_ov = 0;
    end
    now++;
    #1;
  endtask

  task automatic cyc();
    bit f;
    tick(f);
  endtask

  task automatic set_inst(exec_type e, int rd, int rs1, int rs2,
                          bit u1, bit u2, bit we);
    in_valid = 1;
    in_exec  = e;
    in_rd    = RW'(rd);
    in_rs1   = RW'(rs1);
    in_rs2   = RW'(rs2);
    in_use1  = u1;
    in_use2  = u2;
    in_we    = we;
  endtask

  task automatic idle();
    in_valid = 0;
    in_exec  = ENop;
    in_use1  = 0;
    in_use2  = 0;
    in_we    = 0;
    flush    = 0;
    out_ready = 1;
  endtask

  task automatic drain();
    idle();
    repeat (16) cyc();
  endtask

  // Counts DUT stall cycles until in_ready rises; -1 on timeout
  task automatic wait_ready(output int n);
    n = 0;
    while (in_ready !== 1'b1) begin
      if (n >= 40) begin
        n = -1;
        return;
      end
      cyc();
      n++;
    end
  endtask

  task automatic do_reset();
    rst = 1;
    m_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    #1;
  endtask

  task automatic test_reset();
    bit f;
    idle();
    do_reset();
    checks++;
    if (out_valid !== 1'b0 || out_exec !== ENop || out_rd !== '0
        || out_rs1 !== '0 || out_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b e=%0d rd=%0d we=%b want 0/ENop/0/0",
               out_valid, out_exec, out_rd, out_we);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", in_ready);
    end
    set_inst(EFadd, 5, 0, 0, 0, 0, 1);
    tick(f);
    set_inst(EAdd, 1, 5, 0, 1, 0, 1);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_pre_raw: got %b want 0", in_ready);
    end
    rst = 1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: out_valid got %b want 0", out_valid);
    end
    m_clear();
    @(posedge clk);
    #1;
    rst = 0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_clears_cnt: in_ready got %b want 1", in_ready);
    end
    tick(f);
    checks++;
    if (out_valid !== 1'b1 || out_rs1 !== RW'(5)) begin
      errors++;
      $display("FAIL reset_first_issue: got v=%b rs1=%0d want 1/5",
               out_valid, out_rs1);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    set_inst(EAdd, 3, 1, 2, 1, 1, 1);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first_ready: got %b want 1", in_ready);
    end
    cyc();
    set_inst(ESub, 4, 3, 3, 1, 1, 1);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_ready: got rdy=%b v=%b want 1/1",
               in_ready, out_valid);
    end
    cyc();
    checks++;
    if (out_valid !== 1'b1 || out_exec !== ESub || out_rd !== RW'(4)) begin
      errors++;
      $display("FAIL b2b_second_out: got v=%b e=%0d rd=%0d want 1/ESub/4",
               out_valid, out_exec, out_rd);
    end
    drain();
  endtask

  task automatic test_fadd_raw();
    int n;
    set_inst(EFadd, 4, 0, 0, 0, 0, 1);
    cyc();
    set_inst(EAdd, 1, 4, 0, 1, 0, 1);
    #1;
    wait_ready(n);
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL fadd_raw_bubbles: got %0d want 2", n);
    end
    cyc();
    checks++;
    if (out_valid !== 1'b1 || out_rs1 !== RW'(4)) begin
      errors++;
      $display("FAIL fadd_raw_issue: got v=%b rs1=%0d want 1/4",
               out_valid, out_rs1);
    end
    drain();
  endtask

  task automatic test_div_busy();
    int n;
    set_inst(EFdiv, 6, 0, 0, 0, 0, 1);
    cyc();
    set_inst(EAdd, 8, 0, 0, 0, 0, 1);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL div_alu_not_blocked: got %b want 1", in_ready);
    end
    cyc();
    set_inst(EFsqrt, 7, 0, 0, 0, 0, 1);
    #1;
    wait_ready(n);
    checks++;
    if (n != DIV_LAT - 2) begin
      errors++;
      $display("FAIL div_busy_stall: got %0d want %0d", n, DIV_LAT - 2);
    end
    drain();
  endtask

  task automatic test_waw();
    int n;
    set_inst(EFdiv, 9, 0, 0, 0, 0, 1);
    cyc();
    set_inst(EAdd, 9, 0, 0, 0, 0, 1);
    #1;
    wait_ready(n);
    checks++;
    if (n != DIV_LAT - 1) begin
      errors++;
      $display("FAIL waw_stall: got %0d want %0d", n, DIV_LAT - 1);
    end
    cyc();
    drain();
    set_inst(EFadd, 0, 0, 0, 0, 0, 1);
    cyc();
    set_inst(EAdd, 0, 0, 0, 1, 1, 1);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL waw_r0: got %b want 1", in_ready);
    end
    drain();
  endtask

  task automatic test_stall_flush();
    set_inst(EFadd, 2, 0, 0, 0, 0, 1);
    cyc();
    out_ready = 0;
    set_inst(EAdd, 3, 2, 0, 1, 0, 1);
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL out_stall_%0d: got rdy=%b v=%b want 0/1",
                 i, in_ready, out_valid);
      end
      cyc();
    end
    out_ready = 1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_cnt_expired: got %b want 1", in_ready);
    end
    flush = 1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_blocks: got %b want 0", in_ready);
    end
    cyc();
    flush = 0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_kill: got v=%b rdy=%b want 0/1",
               out_valid, in_ready);
    end
    cyc();
    checks++;
    if (out_valid !== 1'b1 || out_rs1 !== RW'(2)) begin
      errors++;
      $display("FAIL flush_next_fire: got v=%b rs1=%0d want 1/2",
               out_valid, out_rs1);
    end
    set_inst(EFdiv, 11, 0, 0, 0, 0, 1);
    cyc();
    set_inst(EAdd, 12, 11, 0, 1, 0, 1);
    flush = 1;
    cyc();
    flush = 0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_keeps_cnt: got %b want 0", in_ready);
    end
    drain();
  endtask

  task automatic test_random();
    bit f;
    bit exp_rdy;
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_exec   = exec_type'($urandom_range(0, 11));
      in_rd     = RW'($urandom_range(0, 7));
      in_rs1    = RW'($urandom_range(0, 7));
      in_rs2    = RW'($urandom_range(0, 7));
      in_use1   = 1'($urandom_range(0, 1));
      in_use2   = 1'($urandom_range(0, 1));
      in_we     = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 11) == 0);
      #1;
      exp_rdy = m_ready();
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL rand_ready[%0d]: got %b want %b", i, in_ready, exp_rdy);
      end
      tick(f);
      checks++;
      if (out_valid !== m_ov
          || (m_ov && (out_exec !== m_exec || out_rd !== m_rd
                       || out_rs1 !== m_rs1 || out_we !== m_we))) begin
        errors++;
        $display("FAIL rand_out[%0d]: got v=%b e=%0d rd=%0d we=%b want %b/%0d/%0d/%b",
                 i, out_valid, out_exec, out_rd, out_we,
                 m_ov, m_exec, m_rd, m_we);
      end
    end
    drain();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    m_clear();
    test_reset();
    test_back_to_back();
    test_fadd_raw();
    test_div_busy();
    test_waw();
    test_stall_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
